// File: rtl/quant_4x4.sv
// quant_4x4: 4x4 forward quantizer; all 16 coefficients are quantized in parallel.
// Latency: one clock, so a block sampled on an enabled edge appears on quantized after that edge.
// Backpressure: none; a block is accepted on every enabled edge, and quantized holds its value otherwise.
module quant_4x4 #(
  parameter int BIT_LENGTH = 31
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       mode,
  input  logic signed [BIT_LENGTH:0] transformed [16],
  input  logic        [3:0]          QP_BY_6,
  input  logic        [2:0]          QP_MOD_6,
  output logic signed [BIT_LENGTH:0] quantized [16]
);

  localparam int DW = BIT_LENGTH + 1;

  logic [5:0]                qbits;
  logic [2:0]                qm;
  logic [63:0]               f_intra;
  logic [63:0]               f_inter;
  logic [63:0]               f_sel;
  logic signed [BIT_LENGTH:0] quantized_d [16];
  logic signed [BIT_LENGTH:0] quantized_q [16];

  // Multiplication factor by position class: A = row and col both even,
  // B = both odd, C = mixed. Bit 2 of k is the row LSB; bit 0 is the col LSB.
  function automatic logic [13:0] mf_lookup(input logic [3:0] k, input logic [2:0] m);
    logic [13:0] mf;
    mf = '0;
    if (!k[2] && !k[0]) begin
      case (m)
        3'd0:    mf = 14'd13107;
        3'd1:    mf = 14'd11916;
        3'd2:    mf = 14'd10082;
        3'd3:    mf = 14'd9362;
        3'd4:    mf = 14'd8192;
        default: mf = 14'd7282;
      endcase
    end else if (k[2] && k[0]) begin
      case (m)
        3'd0:    mf = 14'd5243;
        3'd1:    mf = 14'd4660;
        3'd2:    mf = 14'd4194;
        3'd3:    mf = 14'd3647;
        3'd4:    mf = 14'd3355;
        default: mf = 14'd2893;
      endcase
    end else begin
      case (m)
        3'd0:    mf = 14'd8066;
        3'd1:    mf = 14'd7490;
        3'd2:    mf = 14'd6554;
        3'd3:    mf = 14'd5825;
        3'd4:    mf = 14'd5243;
        default: mf = 14'd4559;
      endcase
    end
    return mf;
  endfunction

  // Sign-magnitude quantization of one coefficient. The magnitude path is
  // 64 bits wide, so |W|*MF + f cannot overflow for any qbits up to 30.
  function automatic logic signed [BIT_LENGTH:0] quant_one(
    input logic signed [BIT_LENGTH:0] w,
    input logic [13:0]                mf,
    input logic [63:0]                f,
    input logic [5:0]                 sh
  );
    logic        neg;
    logic [63:0] w_ext;
    logic [63:0] mag;
    logic [63:0] acc;
    logic [63:0] zmag;
    neg   = w[BIT_LENGTH];
    w_ext = 64'(w);
    mag   = neg ? (64'd0 - w_ext) : w_ext;
    acc   = mag * {50'd0, mf} + f;
    zmag  = acc >> sh;
    return neg ? DW'(64'd0 - zmag) : DW'(zmag);
  endfunction

  assign qbits = 6'd15 + {2'b00, QP_BY_6};
  // QP_MOD_6 codes 6 and 7 are out of range and are folded onto 0.
  assign qm    = (QP_MOD_6 > 3'd5) ? 3'd0 : QP_MOD_6;

  // floor(2^q/3) in binary is 0101...01, with its top set bit at q-2.
  // Selecting the alternating-bit mask by the parity of q and trimming
  // it below q-1 gives the offset without a divider. floor(2^q/6) is
  // the same pattern for q-1.
  assign f_intra = (qbits[0] ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555)
                 & ((64'd1 << (qbits - 6'd1)) - 64'd1);
  assign f_inter = (qbits[0] ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA)
                 & ((64'd1 << (qbits - 6'd2)) - 64'd1);
  assign f_sel   = mode ? f_inter : f_intra;

  // Quantize all 16 coefficients of the current block combinationally.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      quantized_d[k] = quant_one(transformed[k], mf_lookup(4'(k), qm), f_sel, qbits);
    end
  end

  // Output register: reset clears it and takes priority; enable loads it; otherwise it holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) quantized_q[k] <= '0;
    end else if (enable) begin
      quantized_q <= quantized_d;
    end
  end

  assign quantized = quantized_q;

endmodule

// File: tb/tb_quant_4x4.sv
// tb_quant_4x4: directed and randomized blocks are checked against an arithmetic model every cycle.
// Latency: the model predicts the registered output one edge after inputs are sampled.
// Backpressure: none; the bench drives enable directly.
module tb_quant_4x4;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              mode;
  logic signed [31:0] w_in  [16];
  logic        [3:0] qp_by_6;
  logic        [2:0] qp_mod_6;
  logic signed [31:0] z_out [16];

  logic signed [31:0] exp_q [16];
  int                n_checks;
  int                n_fail;
  bit                chk_on;

  quant_4x4 #(.BIT_LENGTH(31)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .transformed (w_in),
    .QP_BY_6     (qp_by_6),
    .QP_MOD_6    (qp_mod_6),
    .quantized   (z_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference quantizer written directly from the arithmetic definition.
  function automatic logic signed [31:0] model_z(input int k, input logic signed [31:0] w,
                                                  input bit md, input int qb, input int qm_in);
    int mf_a [6] = '{13107, 11916, 10082, 9362, 8192, 7282};
    int mf_b [6] = '{5243, 4660, 4194, 3647, 3355, 2893};
    int mf_c [6] = '{8066, 7490, 6554, 5825, 5243, 4559};
    int qm;
    int row;
    int col;
    int mf;
    int q;
    longint unsigned pw;
    longint unsigned f;
    longint unsigned mag;
    longint unsigned z;
    longint r;
    qm  = (qm_in > 5) ? 0 : qm_in;
    row = k / 4;
    col = k % 4;
    if (row % 2 == 0 && col % 2 == 0)      mf = mf_a[qm];
    else if (row % 2 == 1 && col % 2 == 1) mf = mf_b[qm];
    else                                   mf = mf_c[qm];
    q   = 15 + qb;
    pw  = 64'd1 << q;
    f   = md ? pw / 6 : pw / 3;
    mag = (w < 0) ? longint'(-longint'(w)) : longint'(w);
    z   = (mag * longint'(mf) + f) >> q;
    r   = (w < 0) ? -longint'(z) : longint'(z);
    return r[31:0];
  endfunction

  // Model state: follows reset, enable, and hold on every rising edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) exp_q[k] = '0;
    end else if (enable) begin
      for (int k = 0; k < 16; k++)
        exp_q[k] = model_z(k, w_in[k], mode, int'(qp_by_6), int'(qp_mod_6));
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 16; k++) begin
        n_checks++;
        if (z_out[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL model_cmp k=%0d got %0d expected %0d", k, z_out[k], exp_q[k]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int k, input logic signed [31:0] want);
    n_checks++;
    if (z_out[k] !== want) begin
      n_fail++;
      $display("FAIL %s k=%0d got %0d expected %0d", name, k, z_out[k], want);
    end
  endtask

  task automatic clear_w();
    for (int k = 0; k < 16; k++) w_in[k] = '0;
  endtask

  task automatic set_ctl(input bit rst, input bit en, input bit md,
                         input logic [3:0] qb, input logic [2:0] qm);
    reset    = rst;
    enable   = en;
    mode     = md;
    qp_by_6  = qb;
    qp_mod_6 = qm;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_on   = 1'b0;
    for (int k = 0; k < 16; k++) exp_q[k] = '0;
    clear_w();
    set_ctl(1'b1, 1'b0, 1'b0, 4'd0, 3'd0);
    @(negedge clk);
    tick();
    chk_on = 1'b1;
    chk("reset_init", 0, 32'sd0);

    // Position classes at QP 0, intra.
    clear_w();
    w_in[0] = 32'sd5; w_in[1] = -32'sd2; w_in[5] = 32'sd7;
    set_ctl(1'b0, 1'b1, 1'b0, 4'd0, 3'd0);
    tick();
    chk("class_a_w5", 0, 32'sd2);
    chk("class_c_wm2", 1, 32'sd0);
    chk("class_b_w7", 5, 32'sd1);

    // Reset with enable and nonzero inputs discards the block.
    for (int k = 0; k < 16; k++) w_in[k] = 32'sd100 + k;
    set_ctl(1'b1, 1'b1, 1'b0, 4'd0, 3'd0);
    tick();
    chk("reset_prio_0", 0, 32'sd0);
    chk("reset_prio_5", 5, 32'sd0);

    clear_w();
    w_in[0] = 32'sd10;
    set_ctl(1'b0, 1'b1, 1'b0, 4'd0, 3'd0);
    tick();
    chk("class_a_w10", 0, 32'sd4);

    // Rounding mode at QP 0.
    clear_w();
    w_in[0] = 32'sd2;
    tick();
    chk("round_intra", 0, 32'sd1);
    mode = 1'b1;
    tick();
    chk("round_inter", 0, 32'sd0);

    // Sign handling at QP 28.
    clear_w();
    w_in[0] = 32'sd100; w_in[5] = -32'sd200; w_in[2] = -32'sd100;
    set_ctl(1'b0, 1'b1, 1'b0, 4'd4, 3'd4);
    tick();
    chk("qp28_pos", 0, 32'sd1);
    chk("qp28_neg_b", 5, -32'sd1);
    chk("qp28_neg_a", 2, -32'sd1);

    // An out-of-range QP_MOD_6 behaves like 0.
    clear_w();
    w_in[0] = 32'sd2;
    set_ctl(1'b0, 1'b1, 1'b0, 4'd0, 3'd6);
    tick();
    chk("qpmod6_as0", 0, 32'sd1);

    // QP_BY_6 above the legal range is not clamped (qbits = 24).
    clear_w();
    w_in[0] = 32'sd1048576;
    set_ctl(1'b0, 1'b1, 1'b0, 4'd9, 3'd0);
    tick();
    chk("qpby6_9", 0, 32'sd819);

    // Most negative input at QP 0.
    clear_w();
    w_in[0] = 32'sh8000_0000;
    set_ctl(1'b0, 1'b1, 1'b0, 4'd0, 3'd0);
    tick();
    chk("min_int", 0, -32'sd858980352);

    // Hold and latency.
    clear_w();
    w_in[0] = 32'sd10;
    set_ctl(1'b0, 1'b1, 1'b0, 4'd0, 3'd0);
    tick();
    chk("hold_capture", 0, 32'sd4);
    w_in[0] = 32'sd100;
    enable  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_keep", 0, 32'sd4);
    end
    enable = 1'b1;
    tick();
    chk("hold_release", 0, 32'sd40);

    // Reset in the middle of back-to-back enabled blocks.
    w_in[0] = 32'sd5;
    tick();
    chk("stream_a", 0, 32'sd2);
    w_in[0] = 32'sd10;
    tick();
    chk("stream_b", 0, 32'sd4);
    w_in[0] = 32'sd100;
    reset   = 1'b1;
    tick();
    chk("stream_reset", 0, 32'sd0);
    w_in[0] = 32'sd7;
    reset   = 1'b0;
    tick();
    chk("stream_after", 0, 32'sd3);

    // Varied blocks; the model checks every cycle.
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 16; k++) begin
        case ($urandom_range(0, 2))
          0:       w_in[k] = 32'($urandom);
          1:       w_in[k] = 32'($urandom_range(0, 4000)) - 32'sd2000;
          default: w_in[k] = 32'($urandom_range(0, 200000)) - 32'sd100000;
        endcase
      end
      set_ctl(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)));
      tick();
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quant_4x4.md
QUANT_4X4 -- requirements
Module: quant_4x4

Interface
REQ-001 SHALL have parameter BIT_LENGTH, default 31; data words are signed [BIT_LENGTH:0] (32 bits at default).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port enable  input  1  when high, capture and quantize the current block on the rising edge.
REQ-005 SHALL have port mode  input  1  rounding mode: 0 = intra, 1 = inter.
REQ-006 SHALL have port transformed  input  16 x signed [BIT_LENGTH:0]  forward-transform coefficients W[k], k = 4*row + col.
REQ-007 SHALL have port QP_BY_6  input  4  floor(QP/6), legal range 0..8.
REQ-008 SHALL have port QP_MOD_6  input  3  QP mod 6, legal range 0..5.
REQ-009 SHALL have port quantized  output  16 x signed [BIT_LENGTH:0]  registered quantized levels Z[k].

Function
REQ-010 SHALL compute qbits = 15 + QP_BY_6.
REQ-011 SHALL use rounding offset f = floor(2^qbits / 3) when mode = 0, and f = floor(2^qbits / 6) when mode = 1.
REQ-012 SHALL select MF per coefficient position class and QP_MOD_6 (values for QP_MOD_6 = 0..5):
 - class A, (row,col) both even, k in {0,2,8,10}: 13107, 11916, 10082, 9362, 8192, 7282
 - class B, both odd, k in {5,7,13,15}: 5243, 4660, 4194, 3647, 3355, 2893
 - class C, all other k: 8066, 7490, 6554, 5825, 5243, 4559
REQ-013 SHALL compute per coefficient |Z| = (|W|*MF + f) >> qbits (logical right shift, unsigned magnitude).
REQ-014 SHALL give Z the sign of W: Z = -|Z| when W < 0, Z = |Z| otherwise; W = 0 yields Z = 0.
REQ-015 SHALL carry the product and sum at 64 bits minimum so no intermediate overflow occurs for any legal input; the final result is truncated to BIT_LENGTH+1 bits.
REQ-016 SHALL process all 16 coefficients in parallel, with a latency of exactly one clock: inputs sampled on rising edge N appear on quantized after edge N.
REQ-017 SHALL hold quantized unchanged on any rising edge with enable = 0 and reset = 0.
REQ-018 SHALL treat QP_MOD_6 values 6 or 7 as 0.
REQ-019 SHALL process QP_BY_6 values 9..15 arithmetically per REQ-010 with no clamping.
REQ-020 SHALL have no handshake beyond enable; a new block is accepted every enabled cycle (throughput 1 block/clock).
REQ-021 SHALL read mode, QP_BY_6 and QP_MOD_6 in the same cycle as transformed; they are not latched separately.

Reset
REQ-022 SHALL clear all 16 quantized outputs to 0 on a rising edge with reset = 1.
REQ-023 SHALL give reset priority over enable; an enabled block in the reset cycle is discarded.
REQ-024 SHALL retain no other state; the first enabled edge after reset produces a valid result.

Verification
REQ-025 Reset: reset = 1 for one edge with enable = 1 and nonzero inputs -> all quantized = 0.
REQ-026 Rounding mode, QP = 0 (QP_BY_6 = 0, QP_MOD_6 = 0), W[0] = 2, others 0:
 - mode = 0 -> Z[0] = 1
 - mode = 1 -> Z[0] = 0
REQ-027 Position classes, QP = 0, mode = 0:
 - W[0] = 5 -> 2
 - W[0] = 10 -> 4
 - W[1] = -2 -> 0
 - W[5] = 7 (MF 5243: 36701 + 10922 = 47623 >> 15) -> 1
REQ-028 Sign and QP = 28 (QP_BY_6 = 4, QP_MOD_6 = 4), mode = 0:
 - W[0] = 100 -> 1
 - W[5] = -200 -> -1
 - W[2] = -100 -> -1
REQ-029 Hold and latency: apply block A with enable = 1, then change inputs with enable = 0 for 3 cycles -> quantized shows A's result one edge after capture and stays constant; the next enabled edge updates it.
REQ-030 Reset mid-stream: enable high with back-to-back blocks, assert reset for one edge -> outputs 0 that cycle; the next enabled edge yields the correct result for the block present then.
